// File: rtl/debounce_bank.sv
// Multi-channel switch/button debouncer: per-bit synchroniser and stability counter,
// one shared sample-tick prescaler, registered level plus one-cycle rise/fall pulses.
module debounce_bank #(
    parameter int unsigned      WIDTH        = 26,
    parameter int unsigned      TICK_CYCLES  = 1_000_000,
    parameter int unsigned      STABLE_TICKS = 4,
    parameter int unsigned      SYNC_STAGES  = 2,
    parameter logic [WIDTH-1:0] INIT         = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig_i,
    output logic [WIDTH-1:0] sig_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             changed_o,
    output logic             tick_o
);

    localparam int unsigned     PcW    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned     CntW   = $clog2(STABLE_TICKS) + 1;
    localparam logic [PcW-1:0]  PcMax  = PcW'(TICK_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [PcW-1:0]   pc_q, pc_d;
    logic             tick;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= INIT;
            end
        end else begin
            sync_q[0] <= sig_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    assign tick = (pc_q == PcMax);

    always_comb begin
        pc_d = tick ? '0 : pc_q + PcW'(1);
    end

    // Any cycle where the synchronised input agrees with the output restarts that channel.
    always_comb begin
        flip = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync[i] == sig_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CntMax) begin
                    flip[i]  = 1'b1;
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_comb begin
        sig_d     = sig_q ^ flip;
        rise_d    = flip & sync;
        fall_d    = flip & ~sync;
        changed_d = |flip;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            sig_q     <= INIT;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            sig_q     <= sig_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sig_o     = sig_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign changed_o = changed_q;
    assign tick_o    = tick;

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel debouncer for board switches and push-buttons. It replaces per-signal fixed-rate debounce instances with a single block, sitting between the raw FPGA input pins and the CPU's I/O/MMIO logic. Each channel:
- has its own synchroniser and stability counter, and all channels share one programmable tick prescaler;
- outputs a clean level plus one-cycle rise and fall pulses, so downstream logic needs no edge detectors.

## Interface

Parameters:
- WIDTH, 26, number of channels (24 switches + 2 buttons by default)
- TICK_CYCLES, 1_000_000, clk cycles per sample tick (10 ms at 100 MHz); must be ≥1; a value of 1 is used for fast simulation
- STABLE_TICKS, 4, consecutive ticks the input must differ from the output before the output flips; must be ≥1
- SYNC_STAGES, 2, synchroniser depth; must be ≥2
- INIT, {WIDTH{1'b0}}, reset value of the synchronisers and of sig_o, per bit

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset; synchronous and active-high
- sig_i  in  WIDTH  raw asynchronous inputs
- sig_o  out  WIDTH  debounced levels
- rise_o  out  WIDTH  one-cycle pulse per bit when sig_o goes 0→1
- fall_o  out  WIDTH  one-cycle pulse per bit when sig_o goes 1→0
- changed_o  out  1  one-cycle pulse, equal to |(rise_o | fall_o)
- tick_o  out  1  prescaler tick, one cycle wide, for observation and reuse

## Operation

- **Synchroniser:** SYNC_STAGES flops per bit. The last stage is sync[i]. On rst all stages load INIT[i].
- **Prescaler:** counter pc, sized $clog2(TICK_CYCLES).
  - Reset value is 0.
  - pc ← (pc == TICK_CYCLES-1) ? 0 : pc+1.
  - tick = (pc == TICK_CYCLES-1), driven combinationally to tick_o.
- **Per-channel counter:** cnt[i], width $clog2(STABLE_TICKS)+1, reset value 0. Let diff = sync[i] ^ sig_o[i]. Each cycle, in priority order:
  1. diff=0: cnt ← 0. Any bounce back restarts the count, on any cycle, tick or not.
  2. diff=1, tick=1, cnt == STABLE_TICKS-1: sig_o[i] ← sync[i]; cnt ← 0; rise_o[i] ← sync[i]; fall_o[i] ← ~sync[i].
  3. diff=1, tick=1, otherwise: cnt ← cnt+1.
  4. diff=1, tick=0: hold.
- **Registered outputs:** rise_o, fall_o and changed_o are registered. They are 0 on every cycle except the first cycle in which sig_o shows its new value.
- **Independence:** channels are fully independent. Simultaneous flips on several bits assert all the corresponding rise_o/fall_o bits in the same cycle, with a single changed_o pulse.
- **Reset mid-operation:** all counters clear, sig_o and the synchronisers return to INIT, and pulses go to 0. No edge pulse is generated by reset itself.

## Timing

- **Output reset values:** sig_o = INIT; rise_o, fall_o, changed_o = 0; tick_o = 0 (pc = 0).
- **First tick:** the first tick after rst deasserts occurs in the cycle where pc = TICK_CYCLES-1, i.e. the TICK_CYCLES-th cycle.
- **Flip latency:** let sig_i change before edge c and then stay stable. sig_o first shows the new value in the window (STABLE_TICKS-1)·TICK_CYCLES + SYNC_STAGES + 1 … STABLE_TICKS·TICK_CYCLES + SYNC_STAGES cycles after c, depending on tick phase.
- **Glitch rejection:**
  - A glitch whose synchronised width is shorter than (STABLE_TICKS-1)·TICK_CYCLES+1 cycles is always rejected.
  - For STABLE_TICKS=1, any glitch that spans a tick passes.
- **Pulse timing:** pulse outputs are aligned with the sig_o update. There is no extra latency.
- **Width wrap-around:** cnt never exceeds STABLE_TICKS-1, so no wrap is possible.

## Test plan

All scenarios use WIDTH=4, TICK_CYCLES=4, STABLE_TICKS=3, SYNC_STAGES=2, INIT=4'b0000 unless stated.

1. **Reset hold:** hold rst 5 cycles, release, keep sig_i=0 for 100 cycles → sig_o=0, rise_o=fall_o=0, changed_o=0 throughout; tick_o pulses every 4th cycle.
2. **Clean rise:** step sig_i[0] 0→1 at cycle c → sig_o[0]=1 first seen between c+11 and c+14. rise_o=4'b0001 and changed_o=1 for exactly that one cycle. Then step back to 0 → fall_o=4'b0001 for one cycle in the same window.
3. **Bounce rejection:** drive sig_i[1]=1 for 5 cycles, then 0, repeated 10 times at random phase → sig_o[1] stays 0 and no pulses occur. Then hold 1 → it flips within 11–14 cycles.
4. **Simultaneous channels:** raise sig_i[3:2] in the same cycle → rise_o=4'b1100 in a single cycle, changed_o high for exactly 1 cycle, sig_o=4'b1100.
5. **Reset mid-count:** raise sig_i[0], assert rst for 1 cycle after 2 ticks have elapsed (before the flip), keep sig_i[0]=1 → sig_o[0] stays 0 with no pulse. It flips 11–14 cycles after rst deasserts, as if newly applied.
6. **INIT=4'b1111 with sig_i=4'b1111 across reset:** release rst → no fall pulses. Then drop sig_i[2] → fall_o=4'b0100 once within 11–14 cycles.
